interrupt_ack_sequencer: RTL and testbench

- Control-logic block of the 8259A PIC. It sequences the PriorityResolver / IRR / ISR datapath through the 8086-mode INTA handshake.
- Raises INT to the CPU, then detects two INTA pulses:
  - First pulse: freezes IRR sampling, latches the winning index, sets the ISR bit, clears the IRR bit.
  - Second pulse: drives the vector byte onto the data bus.
- Sits between PriorityResolver (INT_request/INT_requestAck, serviced_interrupt_index), the IRR/ISR registers and the bus buffer.

---
 rtl/pic_pkg.sv | 24 ++
 rtl/inta_edge_detect.sv | 20 ++
 rtl/interrupt_ack_sequencer.sv | 178 +++++++++++++++++
 tb/tb_interrupt_ack_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A control-logic slice.
package pic_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PENDING = 3'd1,
      ACK1    = 3'd2,
      GAP     = 3'd3,
      ACK2    = 3'd4
   } state_e;

   localparam logic [2:0]  SPURIOUS_INDEX  = 3'd7;
   localparam int unsigned VECTOR_BASE_MSB = 7;
   localparam int unsigned VECTOR_BASE_LSB = 3;
   localparam int unsigned GAP_CNT_W       = 8;
   localparam int unsigned IDX_W           = 3;

   // Vector byte: ICW2 base bits with the serviced IR index in the low bits
   function automatic logic [7:0] make_vector(input logic [7:0]       icw2,
                                              input logic [IDX_W-1:0] idx);
      return {icw2[VECTOR_BASE_MSB:VECTOR_BASE_LSB], idx};
   endfunction

endpackage

// File: rtl/inta_edge_detect.sv
// Registers INTA_n and flags its falling and rising edges (combinational).
module inta_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic inta_n_i,
   output logic fall_c_o,
   output logic rise_c_o
);

   logic prev_inta_q;

   always_ff @(posedge clk) begin
      if (reset) prev_inta_q <= 1'b1;
      else       prev_inta_q <= inta_n_i;
   end

   assign fall_c_o = prev_inta_q & ~inta_n_i;
   assign rise_c_o = ~prev_inta_q & inta_n_i;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8086-mode INTA handshake sequencer for the 8259A PIC control logic.
// Define AUTO_EOI_EN to pulse ISR_clear at the end of a non-spurious sequence.
module interrupt_ack_sequencer
   import pic_pkg::*;
#(
   parameter int unsigned GAP_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             INTA_n,
   input  logic             INT_request,
   input  logic [IDX_W-1:0] serviced_interrupt_index,
   input  logic [7:0]       ICW2,
   output logic             INT,
   output logic             INT_requestAck,
   output logic             freezing,
   output logic             ISR_set,
   output logic             IRR_clear,
   output logic             ISR_clear,
   output logic [IDX_W-1:0] ISR_index,
   output logic [7:0]       data_out,
   output logic             data_out_en
);

`ifdef AUTO_EOI_EN
   localparam bit AEOI_EN = 1'b1;
`else
   localparam bit AEOI_EN = 1'b0;
`endif

   localparam bit                   TIMEOUT_EN = (GAP_TIMEOUT != 0);
   localparam logic [GAP_CNT_W-1:0] GAP_LIMIT  = GAP_CNT_W'(GAP_TIMEOUT);

   logic fall_c;
   logic rise_c;

   state_e               state_q,     state_d;
   logic                 int_q,       int_d;
   logic                 ack_q,       ack_d;
   logic                 freeze_q,    freeze_d;
   logic                 isr_set_q,   isr_set_d;
   logic                 irr_clear_q, irr_clear_d;
   logic                 isr_clear_q, isr_clear_d;
   logic [IDX_W-1:0]     index_q,     index_d;
   logic [7:0]           dout_q,      dout_d;
   logic                 dout_en_q,   dout_en_d;
   logic [GAP_CNT_W-1:0] gap_q,       gap_d;
   logic                 spurious_q,  spurious_d;
   logic [GAP_CNT_W-1:0] gap_inc_c;

   inta_edge_detect u_edge (
      .clk      (clk),
      .reset    (reset),
      .inta_n_i (INTA_n),
      .fall_c_o (fall_c),
      .rise_c_o (rise_c)
   );

   assign gap_inc_c = gap_q + GAP_CNT_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         int_q       <= 1'b0;
         ack_q       <= 1'b0;
         freeze_q    <= 1'b0;
         isr_set_q   <= 1'b0;
         irr_clear_q <= 1'b0;
         isr_clear_q <= 1'b0;
         index_q     <= '0;
         dout_q      <= '0;
         dout_en_q   <= 1'b0;
         gap_q       <= '0;
         spurious_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         int_q       <= int_d;
         ack_q       <= ack_d;
         freeze_q    <= freeze_d;
         isr_set_q   <= isr_set_d;
         irr_clear_q <= irr_clear_d;
         isr_clear_q <= isr_clear_d;
         index_q     <= index_d;
         dout_q      <= dout_d;
         dout_en_q   <= dout_en_d;
         gap_q       <= gap_d;
         spurious_q  <= spurious_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      int_d       = int_q;
      ack_d       = ack_q;
      freeze_d    = freeze_q;
      isr_set_d   = 1'b0;
      irr_clear_d = 1'b0;
      isr_clear_d = 1'b0;
      index_d     = index_q;
      dout_d      = dout_q;
      dout_en_d   = dout_en_q;
      gap_d       = gap_q;
      spurious_d  = spurious_q;

      unique case (state_q)
         // INTA activity here is ignored; only a request can start a sequence
         IDLE: begin
            int_d = 1'b0;
            if (INT_request) begin
               state_d = PENDING;
               int_d   = 1'b1;
            end
         end
         PENDING: begin
            int_d = 1'b1;
            if (fall_c) begin
               state_d  = ACK1;
               ack_d    = ~ack_q;
               freeze_d = 1'b1;
               int_d    = 1'b0;
               // A request withdrawn before the first pulse is served as IR7
               if (INT_request) begin
                  index_d     = serviced_interrupt_index;
                  isr_set_d   = 1'b1;
                  irr_clear_d = 1'b1;
                  spurious_d  = 1'b0;
               end else begin
                  index_d     = SPURIOUS_INDEX;
                  spurious_d  = 1'b1;
               end
            end
         end
         ACK1: begin
            if (rise_c) begin
               state_d = GAP;
               gap_d   = '0;
            end
         end
         // Abandoned sequences leave the ISR bit set for software EOI
         GAP: begin
            gap_d = gap_inc_c;
            if (fall_c) begin
               state_d   = ACK2;
               dout_d    = make_vector(ICW2, index_q);
               dout_en_d = 1'b1;
            end else if (TIMEOUT_EN && (gap_inc_c == GAP_LIMIT)) begin
               state_d  = IDLE;
               freeze_d = 1'b0;
               gap_d    = '0;
            end
         end
         ACK2: begin
            dout_en_d = 1'b1;
            if (rise_c) begin
               state_d     = IDLE;
               dout_en_d   = 1'b0;
               freeze_d    = 1'b0;
               gap_d       = '0;
               isr_clear_d = AEOI_EN & ~spurious_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign INT            = int_q;
   assign INT_requestAck = ack_q;
   assign freezing       = freeze_q;
   assign ISR_set        = isr_set_q;
   assign IRR_clear      = irr_clear_q;
   assign ISR_clear      = isr_clear_q;
   assign ISR_index      = index_q;
   assign data_out       = dout_q;
   assign data_out_en    = dout_en_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer (GAP_TIMEOUT=10).
module tb_interrupt_ack_sequencer;

`ifdef AUTO_EOI_EN
   localparam bit AEOI = 1'b1;
`else
   localparam bit AEOI = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       INTA_n;
   logic       INT_request;
   logic [2:0] sidx;
   logic [7:0] icw2;
   logic       INT, INT_requestAck, freezing, ISR_set, IRR_clear, ISR_clear, data_out_en;
   logic [2:0] ISR_index;
   logic [7:0] data_out;

   int total = 0;
   int bad   = 0;
   bit exp_ack = 1'b0;

   always #5 clk = ~clk;

   interrupt_ack_sequencer #(.GAP_TIMEOUT(10)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .INTA_n                   (INTA_n),
      .INT_request              (INT_request),
      .serviced_interrupt_index (sidx),
      .ICW2                     (icw2),
      .INT                      (INT),
      .INT_requestAck           (INT_requestAck),
      .freezing                 (freezing),
      .ISR_set                  (ISR_set),
      .IRR_clear                (IRR_clear),
      .ISR_clear                (ISR_clear),
      .ISR_index                (ISR_index),
      .data_out                 (data_out),
      .data_out_en              (data_out_en)
   );

   typedef struct {
      int       rep;
      bit       inta, req;
      bit [2:0] sidx;
      bit [7:0] icw2;
      bit       e_int, e_frz, e_set, e_clr, e_eoi;
      bit [2:0] e_idx;
      bit       e_den;
      bit [7:0] e_dout;
      bit       e_ack;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input int rep, input bit inta, input bit req,
                               input bit [2:0] si, input bit [7:0] w,
                               input bit ei, input bit ef, input bit es, input bit ec,
                               input bit ee, input bit [2:0] ex, input bit ed,
                               input bit [7:0] eo, input bit ea);
      vec_t v;
      v.rep = rep; v.inta = inta; v.req = req; v.sidx = si; v.icw2 = w;
      v.e_int = ei; v.e_frz = ef; v.e_set = es; v.e_clr = ec; v.e_eoi = ee;
      v.e_idx = ex; v.e_den = ed; v.e_dout = eo; v.e_ack = ea;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".INT"},  32'(INT),         32'(0));
      chk({tag, ".frz"},  32'(freezing),    32'(0));
      chk({tag, ".den"},  32'(data_out_en), 32'(0));
      chk({tag, ".set"},  32'(ISR_set),     32'(0));
      chk({tag, ".clr"},  32'(IRR_clear),   32'(0));
      chk({tag, ".ack"},  32'(INT_requestAck), 32'(0));
      chk({tag, ".idx"},  32'(ISR_index),   32'(0));
      chk({tag, ".dout"}, 32'(data_out),    32'(0));
   endtask

   // Full INTA pair starting from PENDING with INTA_n high
   task automatic pair_from_pending(input logic [2:0] idx, input logic [7:0] w);
      logic [7:0] vec;
      vec = {w[7:3], idx};
      INTA_n = 1'b0; tick();
      exp_ack = ~exp_ack;
      chk("p1.set",  32'(ISR_set),   32'(1));
      chk("p1.clr",  32'(IRR_clear), 32'(1));
      chk("p1.idx",  32'(ISR_index), 32'(idx));
      chk("p1.ack",  32'(INT_requestAck), 32'(exp_ack));
      chk("p1.INT",  32'(INT),       32'(0));
      chk("p1.frz",  32'(freezing),  32'(1));
      INT_request = 1'b0; tick();
      chk("p1.set_once", 32'(ISR_set),   32'(0));
      chk("p1.clr_once", 32'(IRR_clear), 32'(0));
      tick(); tick();
      INTA_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("gap.frz", 32'(freezing),    32'(1));
      chk("gap.den", 32'(data_out_en), 32'(0));
      INTA_n = 1'b0; tick();
      chk("p2.den",  32'(data_out_en), 32'(1));
      chk("p2.dout", 32'(data_out),    32'(vec));
      tick(); tick(); tick();
      chk("p2.den_hold", 32'(data_out_en), 32'(1));
      INTA_n = 1'b1; tick();
      chk("end.den", 32'(data_out_en), 32'(0));
      chk("end.frz", 32'(freezing),    32'(0));
      chk("end.eoi", 32'(ISR_clear),   32'(AEOI));
      chk("end.idx", 32'(ISR_index),   32'(idx));
      tick();
      chk("end.eoi_once", 32'(ISR_clear), 32'(0));
      chk("end.INT",      32'(INT),       32'(0));
   endtask

   task automatic do_pair(input logic [2:0] idx, input logic [7:0] w);
      INT_request = 1'b1; sidx = idx; icw2 = w; INTA_n = 1'b1;
      tick();
      chk("req.INT", 32'(INT),      32'(1));
      chk("req.frz", 32'(freezing), 32'(0));
      tick();
      pair_from_pending(idx, w);
   endtask

   initial begin
      reset = 1'b1; INTA_n = 1'b1; INT_request = 1'b0; sidx = '0; icw2 = '0;
      tick(); tick();
      chk_quiet("reset");
      chk("reset.eoi", 32'(ISR_clear), 32'(0));
      reset = 1'b0;
      tick();

      // INTA pulses with no request: nothing moves
      for (int p = 0; p < 2; p++) begin
         INTA_n = 1'b0;
         for (int i = 0; i < 3; i++) begin tick(); chk_quiet("idle_lo"); end
         INTA_n = 1'b1;
         for (int i = 0; i < 3; i++) begin tick(); chk_quiet("idle_hi"); end
      end

      // Normal sequence idx=5 ICW2=40h, then spurious with ICW2=08h
      //   rep inta req si  icw2   INT frz set clr eoi idx den dout   ack
      add(2, 1, 1, 5, 8'h40,  1, 0, 0, 0, 0, 5'd0, 0, 8'h00, 0);
      add(1, 0, 1, 5, 8'h40,  0, 1, 1, 1, 0, 3'd5, 0, 8'h00, 1);
      add(3, 0, 1, 5, 8'h40,  0, 1, 0, 0, 0, 3'd5, 0, 8'h00, 1);
      add(4, 1, 0, 5, 8'h40,  0, 1, 0, 0, 0, 3'd5, 0, 8'h00, 1);
      add(4, 0, 0, 5, 8'h40,  0, 1, 0, 0, 0, 3'd5, 1, 8'h45, 1);
      add(1, 1, 0, 5, 8'h40,  0, 0, 0, 0, 1, 3'd5, 0, 8'h45, 1);
      add(1, 1, 0, 5, 8'h40,  0, 0, 0, 0, 0, 3'd5, 0, 8'h45, 1);
      add(1, 1, 1, 3, 8'h08,  1, 0, 0, 0, 0, 3'd5, 0, 8'h45, 1);
      add(1, 1, 0, 3, 8'h08,  1, 0, 0, 0, 0, 3'd5, 0, 8'h45, 1);
      add(4, 0, 0, 3, 8'h08,  0, 1, 0, 0, 0, 3'd7, 0, 8'h45, 0);
      add(4, 1, 0, 3, 8'h08,  0, 1, 0, 0, 0, 3'd7, 0, 8'h45, 0);
      add(4, 0, 0, 3, 8'h08,  0, 1, 0, 0, 0, 3'd7, 1, 8'h0F, 0);
      add(1, 1, 0, 3, 8'h08,  0, 0, 0, 0, 0, 3'd7, 0, 8'h0F, 0);

      foreach (tbl[r]) begin
         for (int k = 0; k < tbl[r].rep; k++) begin
            string tag;
            tag = $sformatf("row%0d.%0d", r, k);
            INTA_n = tbl[r].inta; INT_request = tbl[r].req;
            sidx = tbl[r].sidx; icw2 = tbl[r].icw2;
            tick();
            chk({tag, ".INT"},  32'(INT),            32'(tbl[r].e_int));
            chk({tag, ".frz"},  32'(freezing),       32'(tbl[r].e_frz));
            chk({tag, ".set"},  32'(ISR_set),        32'(tbl[r].e_set));
            chk({tag, ".clr"},  32'(IRR_clear),      32'(tbl[r].e_clr));
            chk({tag, ".eoi"},  32'(ISR_clear),      32'(AEOI & tbl[r].e_eoi));
            chk({tag, ".idx"},  32'(ISR_index),      32'(tbl[r].e_idx));
            chk({tag, ".den"},  32'(data_out_en),    32'(tbl[r].e_den));
            chk({tag, ".dout"}, 32'(data_out),       32'(tbl[r].e_dout));
            chk({tag, ".ack"},  32'(INT_requestAck), 32'(tbl[r].e_ack));
         end
      end
      exp_ack = 1'b0;

      // Back-to-back requests
      do_pair(3'd3, 8'h40);
      do_pair(3'd1, 8'h40);
      chk("b2b.ack", 32'(INT_requestAck), 32'(0));

      // Fall coincident with request in IDLE is ignored; next pair serves it
      INT_request = 1'b1; sidx = 3'd6; INTA_n = 1'b0;
      tick();
      chk("sim.INT", 32'(INT),      32'(1));
      chk("sim.frz", 32'(freezing), 32'(0));
      chk("sim.set", 32'(ISR_set),  32'(0));
      tick(); tick(); tick();
      INTA_n = 1'b1; tick();
      chk("sim.INT_hold", 32'(INT),      32'(1));
      chk("sim.frz_hold", 32'(freezing), 32'(0));
      pair_from_pending(3'd6, 8'h40);

      // Gap timeout after a single pulse
      INT_request = 1'b1; sidx = 3'd4; tick();
      INTA_n = 1'b0; tick();
      exp_ack = ~exp_ack;
      INT_request = 1'b0;
      tick(); tick(); tick();
      INTA_n = 1'b1; tick();
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk($sformatf("to.frz%0d", k), 32'(freezing),    32'(1));
         chk($sformatf("to.den%0d", k), 32'(data_out_en), 32'(0));
      end
      tick();
      chk("to.frz_drop", 32'(freezing),    32'(0));
      chk("to.den",      32'(data_out_en), 32'(0));
      INTA_n = 1'b0; tick(); tick();
      chk("to.idle_den", 32'(data_out_en), 32'(0));
      chk("to.idle_INT", 32'(INT),         32'(0));
      chk("to.ack",      32'(INT_requestAck), 32'(exp_ack));
      INTA_n = 1'b1; tick();

      // Reset in the middle of ACK2
      INT_request = 1'b1; sidx = 3'd2; icw2 = 8'h40; tick();
      INTA_n = 1'b0; tick();
      INT_request = 1'b0; tick(); tick(); tick();
      INTA_n = 1'b1; tick(); tick(); tick(); tick();
      INTA_n = 1'b0; tick(); tick();
      chk("rst2.den_before", 32'(data_out_en), 32'(1));
      reset = 1'b1; INTA_n = 1'b1; tick();
      chk_quiet("rst2");
      chk("rst2.eoi", 32'(ISR_clear), 32'(0));
      reset = 1'b0; exp_ack = 1'b0;
      INT_request = 1'b1; sidx = 3'd2; tick();
      chk("rst2.restart_INT", 32'(INT), 32'(1));
      pair_from_pending(3'd2, 8'h40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
